// File: rtl/sr_latch_controller.sv
// Round-robin sequencer for a gated SR latch: two requesters, programmable
// setup/enable/hold phases, and a post-operation readback check with sticky error.
module sr_latch_controller #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] op,
    output logic [1:0] ack,
    output logic       busy,
    output logic       S,
    output logic       R,
    output logic       E,
    input  logic       Q,
    input  logic       Q_not,
    output logic       err,
    output logic       err_src,
    input  logic       clr_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    // Counters load length-1 so a phase of N cycles ends when the count reaches zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 32'd1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 32'd1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 32'd1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_q, grant_d;
    logic       exp_q, exp_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic       err_src_q, err_src_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;
    logic [1:0] ack_q, ack_d;
    logic       gsel_s;
    logic       chk_fail_s;

    // Next-state, arbitration and readback-check logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        exp_d      = exp_q;
        last_d     = last_q;
        gsel_s     = 1'b0;
        chk_fail_s = 1'b0;
        if (clr_err) begin
            err_d     = 1'b0;
            err_src_d = 1'b0;
        end else begin
            err_d     = err_q;
            err_src_d = err_src_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    case (req)
                        2'b01:   gsel_s = 1'b0;
                        2'b10:   gsel_s = 1'b1;
                        default: gsel_s = ~last_q;
                    endcase
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    grant_d = gsel_s;
                    exp_d   = op[gsel_s];
                    last_d  = gsel_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d    = ST_CHECK;
                    cnt_d      = 8'd0;
                    // The latch output is sampled exactly once, on the CHECK-entry edge.
                    chk_fail_s = (Q != exp_q) || (Q == Q_not);
                    if (chk_fail_s) begin
                        err_d = 1'b1;
                        if (!err_q || clr_err) begin
                            err_src_d = grant_q;
                        end else begin
                            err_src_d = err_src_q;
                        end
                    end else begin
                        chk_fail_s = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so every latch drive is registered.
    always_comb begin
        s_d    = 1'b0;
        r_d    = 1'b0;
        e_d    = 1'b0;
        ack_d  = 2'b00;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SETUP, ST_HOLD: begin
                s_d = exp_d;
                r_d = ~exp_d;
            end
            ST_PULSE: begin
                s_d = exp_d;
                r_d = ~exp_d;
                e_d = 1'b1;
            end
            ST_CHECK: begin
                ack_d = grant_d ? 2'b10 : 2'b01;
            end
            default: begin
                ack_d = 2'b00;
            end
        endcase
    end

    // State and output registers; reset drops E immediately and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            grant_q   <= 1'b0;
            exp_q     <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            e_q       <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            exp_q     <= exp_d;
            last_q    <= last_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
            s_q       <= s_d;
            r_q       <= r_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign S       = s_q;
    assign R       = r_q;
    assign E       = e_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign err_src = err_src_q;

endmodule

// File: tb/tb_sr_latch_controller.sv
// Scoreboard bench: default-timing instance A and 1/1/1-timing instance B,
// each driving a behavioural gated SR latch.
module tb_sr_latch_controller;

    typedef struct {
        logic [1:0] ack;
        logic       exp;
        logic       err;
        logic       src;
        int         lat;
        int         ecyc;
    } item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_a = 2'b00, op_a = 2'b00, ack_a;
    logic       busy_a, s_a, r_a, e_a, q_a, qn_a, err_a, src_a;
    logic       clr_a = 1'b0, stuck_a = 1'b0, qm_a = 1'b0;
    logic [1:0] req_b = 2'b00, op_b = 2'b00, ack_b;
    logic       busy_b, s_b, r_b, e_b, q_b, qn_b, err_b, src_b;
    logic       qm_b = 1'b0;
    item_t      sb_a[$];
    item_t      sb_b[$];
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sr_latch_controller dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .op(op_a), .ack(ack_a), .busy(busy_a),
        .S(s_a), .R(r_a), .E(e_a), .Q(q_a), .Q_not(qn_a), .err(err_a), .err_src(src_a),
        .clr_err(clr_a)
    );

    sr_latch_controller #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .op(op_b), .ack(ack_b), .busy(busy_b),
        .S(s_b), .R(r_b), .E(e_b), .Q(q_b), .Q_not(qn_b), .err(err_b), .err_src(src_b),
        .clr_err(1'b0)
    );

    // Gated SR latch models; instance A can have Q forced low.
    always @* begin
        if (e_a) begin
            if (s_a) qm_a = 1'b1;
            else if (r_a) qm_a = 1'b0;
        end
        if (e_b) begin
            if (s_b) qm_b = 1'b1;
            else if (r_b) qm_b = 1'b0;
        end
    end
    assign q_a  = stuck_a ? 1'b0 : qm_a;
    assign qn_a = ~qm_a;
    assign q_b  = qm_b;
    assign qn_b = ~qm_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic wait_ack(input bit use_b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((use_b ? ack_b : ack_a) != 2'b00) return;
        end
        chk("ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_e(input bit use_b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((use_b ? e_b : e_a) == 1'b1) return;
        end
        chk("enable_timeout", 32'd1, 32'd0);
    endtask

    // Monitor A: latency, enable width, phase drive and ack contents.
    initial begin
        int lat = 0, ecyc = 0;
        logic busy_p = 1'b0;
        item_t it;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat = 0; ecyc = 0; busy_p = 1'b0;
            end else begin
                chk("a_s_and_r", 32'(s_a & r_a), 32'd0);
                chk("a_e_without_sr", 32'(e_a & ~(s_a | r_a)), 32'd0);
                if (busy_a && !busy_p) begin
                    lat = 0; ecyc = 0;
                end else if (busy_a) begin
                    lat++;
                end
                if (e_a) ecyc++;
                if (busy_a && ack_a == 2'b00 && sb_a.size() > 0)
                    chk("a_sr_phase", 32'({s_a, r_a}), 32'({sb_a[0].exp, ~sb_a[0].exp}));
                if (ack_a != 2'b00) begin
                    if (sb_a.size() == 0) begin
                        chk("a_unexpected_ack", 32'(ack_a), 32'd0);
                    end else begin
                        it = sb_a.pop_front();
                        chk("a_ack", 32'(ack_a), 32'(it.ack));
                        chk("a_latency", lat, it.lat);
                        chk("a_e_cycles", ecyc, it.ecyc);
                        chk("a_err", 32'(err_a), 32'(it.err));
                        chk("a_err_src", 32'(src_a), 32'(it.src));
                        chk("a_check_sre", 32'({s_a, r_a, e_a}), 32'd0);
                    end
                end
                busy_p = busy_a;
            end
        end
    end

    // Monitor B: same checks for the short-timing instance.
    initial begin
        int lat = 0, ecyc = 0;
        logic busy_p = 1'b0;
        item_t it;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat = 0; ecyc = 0; busy_p = 1'b0;
            end else begin
                chk("b_s_and_r", 32'(s_b & r_b), 32'd0);
                if (busy_b && !busy_p) begin
                    lat = 0; ecyc = 0;
                end else if (busy_b) begin
                    lat++;
                end
                if (e_b) ecyc++;
                if (busy_b && ack_b == 2'b00 && sb_b.size() > 0)
                    chk("b_sr_phase", 32'({s_b, r_b}), 32'({sb_b[0].exp, ~sb_b[0].exp}));
                if (ack_b != 2'b00) begin
                    if (sb_b.size() == 0) begin
                        chk("b_unexpected_ack", 32'(ack_b), 32'd0);
                    end else begin
                        it = sb_b.pop_front();
                        chk("b_ack", 32'(ack_b), 32'(it.ack));
                        chk("b_latency", lat, it.lat);
                        chk("b_e_cycles", ecyc, it.ecyc);
                        chk("b_err", 32'(err_b), 32'(it.err));
                    end
                end
                busy_p = busy_b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_sre", 32'({s_a, r_a, e_a}), 32'd0);
        chk("reset_ack_err", 32'({ack_a, err_a, src_a}), 32'd0);

        // Requester 0 sets, then requester 1 clears.
        op_a = 2'b01; req_a = 2'b01;
        sb_a.push_back('{ack: 2'b01, exp: 1'b1, err: 1'b0, src: 1'b0, lat: 8, ecyc: 4});
        wait_ack(1'b0);
        req_a = 2'b00;
        @(negedge clk);
        chk("set_q", 32'({q_a, qn_a}), 32'b10);
        op_a = 2'b00; req_a = 2'b10;
        sb_a.push_back('{ack: 2'b10, exp: 1'b0, err: 1'b0, src: 1'b0, lat: 8, ecyc: 4});
        wait_ack(1'b0);
        req_a = 2'b00;
        @(negedge clk);
        chk("clear_q", 32'({q_a, qn_a}), 32'b01);

        // Contention held from reset: grants alternate 0,1,0,1 with one idle cycle between.
        rst_n = 1'b0;
        op_a = 2'b01; req_a = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            sb_a.push_back('{ack: (i % 2 == 0) ? 2'b01 : 2'b10, exp: (i % 2 == 0),
                             err: 1'b0, src: 1'b0, lat: 8, ecyc: 4});
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0);
            if (i == 3) req_a = 2'b00;
            @(negedge clk);
            chk("idle_gap", 32'(busy_a), 32'd0);
            if (i < 3) begin
                @(negedge clk);
                chk("regrant", 32'(busy_a), 32'd1);
            end
        end

        // Q stuck low while requester 1 sets: error flagged against requester 1.
        stuck_a = 1'b1;
        op_a = 2'b10; req_a = 2'b10;
        sb_a.push_back('{ack: 2'b10, exp: 1'b1, err: 1'b1, src: 1'b1, lat: 8, ecyc: 4});
        wait_ack(1'b0);
        req_a = 2'b00;
        stuck_a = 1'b0;
        @(negedge clk);
        op_a = 2'b01; req_a = 2'b01;
        sb_a.push_back('{ack: 2'b01, exp: 1'b1, err: 1'b1, src: 1'b1, lat: 8, ecyc: 4});
        wait_ack(1'b0);
        req_a = 2'b00;
        @(negedge clk);
        chk("err_sticky", 32'({err_a, src_a}), 32'b11);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("err_cleared", 32'({err_a, src_a}), 32'b00);

        // Reset mid-PULSE: everything drops with no clock edge and no ack follows.
        op_a = 2'b01; req_a = 2'b01;
        wait_e(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({e_a, s_a, r_a, busy_a, ack_a, err_a}), 32'd0);
        req_a = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'({busy_a, ack_a}), 32'd0);

        // Short timing: plain set, then a clear whose req drops during PULSE.
        op_b = 2'b01; req_b = 2'b01;
        sb_b.push_back('{ack: 2'b01, exp: 1'b1, err: 1'b0, src: 1'b0, lat: 3, ecyc: 1});
        wait_ack(1'b1);
        req_b = 2'b00;
        @(negedge clk);
        chk("b_set_q", 32'(q_b), 32'd1);
        op_b = 2'b00; req_b = 2'b01;
        sb_b.push_back('{ack: 2'b01, exp: 1'b0, err: 1'b0, src: 1'b0, lat: 3, ecyc: 1});
        wait_e(1'b1);
        req_b = 2'b00;
        wait_ack(1'b1);
        @(negedge clk);
        chk("b_clear_q", 32'(q_b), 32'd0);

        repeat (4) @(negedge clk);
        chk("a_scoreboard_drained", sb_a.size(), 32'd0);
        chk("b_scoreboard_drained", sb_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
